// File: rtl/k2_seq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | k2_seq_pkg : shared types and default widths for the K2 program sequencer  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package k2_seq_pkg;

   localparam int K2_BITS   = 8;
   localparam int K2_ADDR_W = 4;
   localparam int K2_INST_W = 8;
   localparam int K2_CYC_W  = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      RUN  = 2'd2,
      DONE = 2'd3
   } state_t;

endpackage
`default_nettype wire

// File: rtl/k2_program_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | k2_program_sequencer_if : loader, control, core and status signal bundle   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface k2_program_sequencer_if
   import k2_seq_pkg::*;
#(
   parameter int BITS   = K2_BITS,
   parameter int ADDR_W = K2_ADDR_W,
   parameter int INST_W = K2_INST_W,
   parameter int CYC_W  = K2_CYC_W
);
   logic              start_load;
   logic              ld_valid;
   logic [INST_W-1:0] ld_data;
   logic              ld_ready;
   logic              run_req;
   logic              halt_req;
   logic [CYC_W-1:0]  cycle_limit;
   logic [ADDR_W-1:0] cpu_addr;
   logic [INST_W-1:0] cpu_inst;
   logic              cpu_rst_n;
   logic [BITS-1:0]   cpu_ro;
   logic [BITS-1:0]   result;
   logic              result_valid;
   logic [CYC_W-1:0]  cycles;
   logic [1:0]        state_o;

   modport master (
      output start_load, ld_valid, ld_data, run_req, halt_req, cycle_limit,
             cpu_addr, cpu_ro,
      input  ld_ready, cpu_inst, cpu_rst_n, result, result_valid, cycles, state_o
   );

   modport slave (
      input  start_load, ld_valid, ld_data, run_req, halt_req, cycle_limit,
             cpu_addr, cpu_ro,
      output ld_ready, cpu_inst, cpu_rst_n, result, result_valid, cycles, state_o
   );

endinterface
`default_nettype wire

// File: rtl/k2_inst_ram.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | k2_inst_ram : instruction store, one sync write port, one async read port  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module k2_inst_ram
   import k2_seq_pkg::*;
#(
   parameter int ADDR_W = K2_ADDR_W,
   parameter int INST_W = K2_INST_W
) (
   input  wire logic              clk,
   input  wire logic              rst,
   input  wire logic              i_we,
   input  wire logic [ADDR_W-1:0] i_waddr,
   input  wire logic [INST_W-1:0] i_wdata,
   input  wire logic [ADDR_W-1:0] i_raddr,
   output logic      [INST_W-1:0] o_rdata
);
   localparam int DEPTH = 2 ** ADDR_W;

   logic [INST_W-1:0] r_mem [DEPTH];

   // Whole array clears on reset so a fresh core never fetches stale code.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata = r_mem[i_raddr];

endmodule
`default_nettype wire

// File: rtl/k2_program_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | k2_program_sequencer : loads a program, runs one K2 core, captures Ro      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module k2_program_sequencer
   import k2_seq_pkg::*;
#(
   parameter int BITS   = K2_BITS,
   parameter int ADDR_W = K2_ADDR_W,
   parameter int INST_W = K2_INST_W,
   parameter int CYC_W  = K2_CYC_W
) (
   input  wire logic             clk,
   input  wire logic             rst,
   k2_program_sequencer_if.slave bus
);
   state_t            r_state;
   state_t            w_state_nxt;
   logic [ADDR_W:0]   r_wr_ptr;
   logic [CYC_W-1:0]  r_cycles;
   logic [CYC_W-1:0]  w_cyc_inc;
   logic              r_cpu_rst_n;
   logic [BITS-1:0]   r_result;
   logic              r_result_valid;
   logic              w_wr_en;
   logic              w_load_start;
   logic              w_run_start;
   logic              w_run_stop;
   logic              w_limit_hit;
   logic [INST_W-1:0] w_rdata;

   assign w_cyc_inc   = (r_cycles == '1) ? r_cycles : r_cycles + 1'b1;
   assign w_limit_hit = (bus.cycle_limit != '0) &&
                        (r_cycles == bus.cycle_limit - 1'b1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_wr_en      = 1'b0;
      w_load_start = 1'b0;
      w_run_start  = 1'b0;
      w_run_stop   = 1'b0;
      case (r_state)
         IDLE, DONE: begin
            if (bus.start_load) begin
               w_state_nxt  = LOAD;
               w_load_start = 1'b1;
            end else if (bus.run_req) begin
               w_state_nxt = RUN;
               w_run_start = 1'b1;
            end
         end
         LOAD: begin
            // The pointer's top bit guards against a second pass over the RAM.
            if (bus.halt_req) begin
               w_state_nxt = IDLE;
            end else if (bus.ld_valid && !r_wr_ptr[ADDR_W]) begin
               w_wr_en = 1'b1;
               if (r_wr_ptr[ADDR_W-1:0] == '1) begin
                  w_state_nxt = IDLE;
               end
            end
         end
         RUN: begin
            if (bus.halt_req || w_limit_hit) begin
               w_state_nxt = DONE;
               w_run_stop  = 1'b1;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
      end else if (w_load_start) begin
         r_wr_ptr <= '0;
      end else if (w_wr_en) begin
         r_wr_ptr <= r_wr_ptr + 1'b1;
      end
   end

   // The exit edge still counts, so a limit stop leaves cycles == cycle_limit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cycles <= '0;
      end else if (w_run_start) begin
         r_cycles <= '0;
      end else if (r_state == RUN) begin
         r_cycles <= w_cyc_inc;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cpu_rst_n    <= 1'b0;
         r_result       <= '0;
         r_result_valid <= 1'b0;
      end else begin
         if (w_run_start) begin
            r_cpu_rst_n <= 1'b1;
         end else if (w_run_stop) begin
            r_cpu_rst_n <= 1'b0;
         end
         if (w_run_stop) begin
            r_result       <= bus.cpu_ro;
            r_result_valid <= 1'b1;
         end else if (w_load_start || w_run_start) begin
            r_result_valid <= 1'b0;
         end
      end
   end

   k2_inst_ram #(
      .ADDR_W (ADDR_W),
      .INST_W (INST_W)
   ) u_ram (
      .clk     (clk),
      .rst     (rst),
      .i_we    (w_wr_en),
      .i_waddr (r_wr_ptr[ADDR_W-1:0]),
      .i_wdata (bus.ld_data),
      .i_raddr (bus.cpu_addr),
      .o_rdata (w_rdata)
   );

   assign bus.ld_ready     = (r_state == LOAD);
   assign bus.cpu_inst     = w_rdata;
   assign bus.cpu_rst_n    = r_cpu_rst_n;
   assign bus.result       = r_result;
   assign bus.result_valid = r_result_valid;
   assign bus.cycles       = r_cycles;
   assign bus.state_o      = r_state;

endmodule
`default_nettype wire

// File: tb/tb_k2_program_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_k2_program_sequencer : directed self-checking bench for the sequencer   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_k2_program_sequencer;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   k2_program_sequencer_if bus ();

   k2_program_sequencer dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_run  = 0;
   int n_fail = 0;

   typedef struct {
      int         phase;
      logic [3:0] addr;
      logic [7:0] exp;
   } rd_vec_t;

   rd_vec_t vecs[17];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_run++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check_ram(input int phase);
      for (int i = 0; i < 17; i++) begin
         if (vecs[i].phase == phase) begin
            bus.cpu_addr = vecs[i].addr;
            #1;
            check($sformatf("ram_p%0d_a%0d", phase, vecs[i].addr),
                  32'(bus.cpu_inst), 32'(vecs[i].exp));
         end
      end
   endtask

   initial begin
      int acc;
      int n_hi;
      int cyc;

      vecs[0]  = '{0, 4'd0,  8'h00};
      vecs[1]  = '{0, 4'd7,  8'h00};
      vecs[2]  = '{0, 4'd15, 8'h00};
      vecs[3]  = '{1, 4'd0,  8'h10};
      vecs[4]  = '{1, 4'd5,  8'h15};
      vecs[5]  = '{1, 4'd9,  8'h19};
      vecs[6]  = '{1, 4'd15, 8'h1F};
      vecs[7]  = '{2, 4'd0,  8'h80};
      vecs[8]  = '{2, 4'd1,  8'h81};
      vecs[9]  = '{2, 4'd2,  8'h82};
      vecs[10] = '{2, 4'd3,  8'h83};
      vecs[11] = '{2, 4'd4,  8'h84};
      vecs[12] = '{2, 4'd5,  8'h15};
      vecs[13] = '{2, 4'd6,  8'h16};
      vecs[14] = '{3, 4'd0,  8'h00};
      vecs[15] = '{3, 4'd5,  8'h00};
      vecs[16] = '{3, 4'd15, 8'h00};

      bus.start_load  = 1'b0;
      bus.ld_valid    = 1'b0;
      bus.ld_data     = '0;
      bus.run_req     = 1'b0;
      bus.halt_req    = 1'b0;
      bus.cycle_limit = '0;
      bus.cpu_addr    = '0;
      bus.cpu_ro      = '0;

      // Reset state
      tick;
      tick;
      check("rst_state", 32'(bus.state_o), 32'd0);
      check("rst_ld_ready", 32'(bus.ld_ready), 32'd0);
      check("rst_cpu_rst_n", 32'(bus.cpu_rst_n), 32'd0);
      check("rst_result", 32'(bus.result), 32'd0);
      check("rst_result_valid", 32'(bus.result_valid), 32'd0);
      check("rst_cycles", 32'(bus.cycles), 32'd0);
      check_ram(0);
      rst = 1'b0;
      tick;

      // 1: full load with valid gaps
      bus.start_load = 1'b1;
      tick;
      bus.start_load = 1'b0;
      check("t1_state_load", 32'(bus.state_o), 32'd1);
      acc = 0;
      cyc = 0;
      while (acc < 16 && cyc < 200) begin
         bus.ld_valid = ((cyc % 3) != 2);
         bus.ld_data  = 8'h10 + 8'(acc);
         #1;
         if (bus.ld_valid && bus.ld_ready) acc++;
         tick;
         cyc++;
      end
      bus.ld_valid = 1'b0;
      check("t1_accepts", 32'(acc), 32'd16);
      check("t1_ld_ready_low", 32'(bus.ld_ready), 32'd0);
      check("t1_state_idle", 32'(bus.state_o), 32'd0);
      tick;
      check("t1_ld_ready_stays_low", 32'(bus.ld_ready), 32'd0);
      check_ram(1);

      // 2: limited run of 20 cycles
      bus.cycle_limit = 16'd20;
      bus.cpu_ro      = 8'hA5;
      bus.run_req     = 1'b1;
      tick;
      bus.run_req = 1'b0;
      check("t2_state_run", 32'(bus.state_o), 32'd2);
      n_hi = bus.cpu_rst_n ? 1 : 0;
      cyc  = 0;
      while (bus.state_o != 2'd3 && cyc < 100) begin
         tick;
         if (bus.cpu_rst_n) n_hi++;
         cyc++;
      end
      check("t2_rst_n_high_cycles", 32'(n_hi), 32'd20);
      check("t2_state_done", 32'(bus.state_o), 32'd3);
      check("t2_cycles", 32'(bus.cycles), 32'd20);
      check("t2_result", 32'(bus.result), 32'hA5);
      check("t2_result_valid", 32'(bus.result_valid), 32'd1);
      check("t2_cpu_rst_n_low", 32'(bus.cpu_rst_n), 32'd0);

      // 3: halted partial load; run_req during LOAD ignored
      bus.start_load = 1'b1;
      tick;
      bus.start_load = 1'b0;
      check("t3_state_load", 32'(bus.state_o), 32'd1);
      check("t3_result_valid_clr", 32'(bus.result_valid), 32'd0);
      for (int k = 0; k < 5; k++) begin
         bus.ld_valid = 1'b1;
         bus.ld_data  = 8'h80 + 8'(k);
         bus.run_req  = (k == 0);
         tick;
         check($sformatf("t3_state_load_k%0d", k), 32'(bus.state_o), 32'd1);
      end
      bus.run_req  = 1'b0;
      bus.ld_data  = 8'h85;
      bus.halt_req = 1'b1;
      tick;
      bus.halt_req = 1'b0;
      bus.ld_valid = 1'b0;
      check("t3_state_idle", 32'(bus.state_o), 32'd0);
      check_ram(2);

      // 4: halt and limit coincide on the 3rd RUN cycle
      bus.cycle_limit = 16'd3;
      bus.cpu_ro      = 8'h3C;
      bus.run_req     = 1'b1;
      tick;
      bus.run_req = 1'b0;
      tick;
      tick;
      check("t4_cycles_before", 32'(bus.cycles), 32'd2);
      bus.halt_req = 1'b1;
      tick;
      bus.halt_req = 1'b0;
      bus.cpu_ro   = 8'h77;
      check("t4_state_done", 32'(bus.state_o), 32'd3);
      check("t4_cycles", 32'(bus.cycles), 32'd3);
      check("t4_result", 32'(bus.result), 32'h3C);
      tick;
      tick;
      check("t4_result_held", 32'(bus.result), 32'h3C);
      check("t4_valid_held", 32'(bus.result_valid), 32'd1);
      check("t4_cycles_held", 32'(bus.cycles), 32'd3);

      // 6: start_load beats run_req in DONE
      bus.start_load = 1'b1;
      bus.run_req    = 1'b1;
      tick;
      bus.start_load = 1'b0;
      bus.run_req    = 1'b0;
      check("t6_state_load", 32'(bus.state_o), 32'd1);
      check("t6_result_valid", 32'(bus.result_valid), 32'd0);
      check("t6_cpu_rst_n", 32'(bus.cpu_rst_n), 32'd0);
      bus.halt_req = 1'b1;
      tick;
      bus.halt_req = 1'b0;
      check("t6_state_idle", 32'(bus.state_o), 32'd0);
      check("t6_result_kept", 32'(bus.result), 32'h3C);

      // 5: async reset in the middle of an unlimited run
      bus.cycle_limit = 16'd0;
      bus.cpu_ro      = 8'h5A;
      bus.run_req     = 1'b1;
      tick;
      bus.run_req = 1'b0;
      tick;
      tick;
      tick;
      tick;
      check("t5_cycles_running", 32'(bus.cycles), 32'd4);
      check("t5_cpu_rst_n_high", 32'(bus.cpu_rst_n), 32'd1);
      #2;
      rst = 1'b1;
      #1;
      check("t5_cpu_rst_n_async", 32'(bus.cpu_rst_n), 32'd0);
      check("t5_state", 32'(bus.state_o), 32'd0);
      check("t5_cycles", 32'(bus.cycles), 32'd0);
      check("t5_result", 32'(bus.result), 32'd0);
      check("t5_result_valid", 32'(bus.result_valid), 32'd0);
      tick;
      rst = 1'b0;
      check_ram(3);
      tick;
      check("t5_state_after", 32'(bus.state_o), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
